// File: rtl/video_rx_monitor.sv
// Decodes an HS/VS/BLANK/RGB video stream into pixel coordinates and per-frame geometry status.
// Optional feature macro RX_CHECKSUM_EN adds a per-frame RGB checksum output (frame_sum).
module video_rx_monitor #(
    parameter int HDISP = 800,
    parameter int VDISP = 480,
    parameter int XW    = $clog2(HDISP + 1),
    parameter int YW    = $clog2(VDISP + 1)
) (
    input  logic          pixel_clk,
    input  logic          pixel_rst,
    input  logic          vid_hs,
    input  logic          vid_vs,
    input  logic          vid_blank,
    input  logic [23:0]   vid_rgb,
    output logic          pix_valid,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic [23:0]   pix_rgb,
    output logic          locked,
    output logic          frame_done,
    output logic [15:0]   frame_cnt,
    output logic          err_hsize,
    output logic          err_vsize,
    output logic [YW-1:0] last_lines
`ifdef RX_CHECKSUM_EN
    ,
    output logic [31:0]   frame_sum
`endif
);

    typedef enum logic {
        SEEK,
        FRAME
    } state_t;

    localparam logic [XW-1:0] HDISP_X = XW'(HDISP);
    localparam logic [YW-1:0] VDISP_Y = YW'(VDISP);

    function automatic logic [XW-1:0] sat_inc_x(input logic [XW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [YW-1:0] sat_inc_y(input logic [YW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_t state_q, state_d;

    logic          hs_p0_q, vs_p0_q, blank_p0_q;
    logic          hs_p1_q, vs_p1_q, blank_p1_q;
    logic [23:0]   rgb_p0_q;

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          herr_q, herr_d;
    logic          skip_q, skip_d;

    logic          pix_valid_q, pix_valid_d;
    logic [XW-1:0] pix_x_q, pix_x_d;
    logic [YW-1:0] pix_y_q, pix_y_d;
    logic [23:0]   pix_rgb_q, pix_rgb_d;
    logic          locked_q, locked_d;
    logic          done_q, done_d;
    logic [15:0]   cnt_q, cnt_d;
    logic          err_h_q, err_h_d;
    logic          err_v_q, err_v_d;
    logic [YW-1:0] last_q, last_d;

`ifdef RX_CHECKSUM_EN
    logic [31:0]   sum_q, sum_d;
    logic [31:0]   fsum_q, fsum_d;
`endif

    logic hs_fall, vs_fall, blank_fall, active;

    // Stage p0/p1: registered inputs and their previous values for edge detection
    always_comb begin
        hs_fall    = hs_p1_q & ~hs_p0_q;
        vs_fall    = vs_p1_q & ~vs_p0_q;
        blank_fall = blank_p1_q & ~blank_p0_q;
        active     = blank_p0_q & ~skip_q;
    end

    // Decode stage: counters, frame FSM and registered outputs
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        herr_d      = herr_q;
        skip_d      = skip_q;
        locked_d    = locked_q;
        done_d      = 1'b0;
        cnt_d       = cnt_q;
        err_h_d     = err_h_q;
        err_v_d     = err_v_q;
        last_d      = last_q;
        pix_valid_d = blank_p0_q && (state_q == FRAME);
        pix_x_d     = x_q;
        pix_y_d     = y_q;
        pix_rgb_d   = rgb_p0_q;
`ifdef RX_CHECKSUM_EN
        sum_d       = sum_q;
        fsum_d      = fsum_q;
`endif

        case (state_q)
            SEEK: begin
                if (vs_fall) begin
                    state_d  = FRAME;
                    locked_d = 1'b1;
                    x_d      = '0;
                    y_d      = '0;
                    herr_d   = 1'b0;
                    skip_d   = blank_p0_q;
`ifdef RX_CHECKSUM_EN
                    sum_d    = '0;
`endif
                end
            end
            FRAME: begin
                if (active) begin
                    x_d = sat_inc_x(x_q);
`ifdef RX_CHECKSUM_EN
                    sum_d = sum_q + {8'd0, rgb_p0_q};
`endif
                end
                if (hs_fall && active)
                    herr_d = 1'b1;
                if (blank_fall && !skip_q) begin
                    if (x_q != HDISP_X)
                        herr_d = 1'b1;
                    y_d = sat_inc_y(y_q);
                    x_d = '0;
                end
                if (!blank_p0_q)
                    skip_d = 1'b0;
                if (vs_fall) begin
                    // A run still open at frame start is closed as a faulty line
                    if (active) begin
                        herr_d = 1'b1;
                        y_d    = sat_inc_y(y_q);
                    end
                    done_d  = 1'b1;
                    err_h_d = herr_d;
                    err_v_d = (y_d != VDISP_Y);
                    last_d  = y_d;
                    cnt_d   = cnt_q + 16'd1;
`ifdef RX_CHECKSUM_EN
                    fsum_d  = sum_d;
                    sum_d   = '0;
`endif
                    x_d     = '0;
                    y_d     = '0;
                    herr_d  = 1'b0;
                    // The remainder of that run belongs to the old frame
                    skip_d  = blank_p0_q;
                end
            end
            default: state_d = SEEK;
        endcase
    end

    always_ff @(posedge pixel_clk) begin
        if (pixel_rst) begin
            hs_p0_q     <= 1'b1;
            vs_p0_q     <= 1'b1;
            blank_p0_q  <= 1'b0;
            hs_p1_q     <= 1'b1;
            vs_p1_q     <= 1'b1;
            blank_p1_q  <= 1'b0;
            state_q     <= SEEK;
            x_q         <= '0;
            y_q         <= '0;
            herr_q      <= 1'b0;
            skip_q      <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            pix_rgb_q   <= '0;
            locked_q    <= 1'b0;
            done_q      <= 1'b0;
            cnt_q       <= '0;
            err_h_q     <= 1'b0;
            err_v_q     <= 1'b0;
            last_q      <= '0;
`ifdef RX_CHECKSUM_EN
            sum_q       <= '0;
            fsum_q      <= '0;
`endif
        end else begin
            hs_p0_q     <= vid_hs;
            vs_p0_q     <= vid_vs;
            blank_p0_q  <= vid_blank;
            hs_p1_q     <= hs_p0_q;
            vs_p1_q     <= vs_p0_q;
            blank_p1_q  <= blank_p0_q;
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            herr_q      <= herr_d;
            skip_q      <= skip_d;
            pix_valid_q <= pix_valid_d;
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
            pix_rgb_q   <= pix_rgb_d;
            locked_q    <= locked_d;
            done_q      <= done_d;
            cnt_q       <= cnt_d;
            err_h_q     <= err_h_d;
            err_v_q     <= err_v_d;
            last_q      <= last_d;
`ifdef RX_CHECKSUM_EN
            sum_q       <= sum_d;
            fsum_q      <= fsum_d;
`endif
        end
    end

    always_ff @(posedge pixel_clk) begin
        rgb_p0_q <= vid_rgb;
    end

    assign pix_valid  = pix_valid_q;
    assign pix_x      = pix_x_q;
    assign pix_y      = pix_y_q;
    assign pix_rgb    = pix_rgb_q;
    assign locked     = locked_q;
    assign frame_done = done_q;
    assign frame_cnt  = cnt_q;
    assign err_hsize  = err_h_q;
    assign err_vsize  = err_v_q;
    assign last_lines = last_q;
`ifdef RX_CHECKSUM_EN
    assign frame_sum  = fsum_q;
`endif

endmodule

// File: tb/tb_video_rx_monitor.sv
// Directed self-checking bench for video_rx_monitor on a 160x90 geometry.
`timescale 1ns/1ps
module tb_video_rx_monitor;
    localparam int HD = 160;
    localparam int VD = 90;
    localparam int XW = $clog2(HD + 1);
    localparam int YW = $clog2(VD + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          hs, vs, blank;
    logic [23:0]   rgb;
    logic          pix_valid;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic [23:0]   pix_rgb;
    logic          locked, frame_done, err_hsize, err_vsize;
    logic [15:0]   frame_cnt;
    logic [YW-1:0] last_lines;
`ifdef RX_CHECKSUM_EN
    logic [31:0]   frame_sum;
`endif

    int checks = 0;
    int errors = 0;
    int pv_cnt = 0, fd_cnt = 0;
    int npix = 0, pix_bad = 0, mx = 0, my = 0;
    logic mon_en = 1'b0;
    int pv0, fd0;

    always #5 clk = ~clk;

    video_rx_monitor #(.HDISP(HD), .VDISP(VD)) dut (
        .pixel_clk (clk),
        .pixel_rst (rst),
        .vid_hs    (hs),
        .vid_vs    (vs),
        .vid_blank (blank),
        .vid_rgb   (rgb),
        .pix_valid (pix_valid),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_rgb   (pix_rgb),
        .locked    (locked),
        .frame_done(frame_done),
        .frame_cnt (frame_cnt),
        .err_hsize (err_hsize),
        .err_vsize (err_vsize),
        .last_lines(last_lines)
`ifdef RX_CHECKSUM_EN
        ,
        .frame_sum (frame_sum)
`endif
    );

    // Output monitor: pulse counts plus an in-order coordinate/colour model for one frame
    always @(negedge clk) begin
        if (pix_valid) pv_cnt++;
        if (frame_done) fd_cnt++;
        if (mon_en && pix_valid) begin
            if (pix_x !== XW'(mx) || pix_y !== YW'(my) || pix_rgb !== {8'(my), 16'(mx)})
                pix_bad++;
            npix++;
            mx++;
            if (mx == HD) begin
                mx = 0;
                my++;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic h, input logic v, input logic b, input logic [23:0] c);
        hs = h; vs = v; blank = b; rgb = c;
        @(posedge clk);
        #1;
    endtask

    task automatic line(input int n, input int y, input bit one);
        for (int i = 0; i < n; i++) drv(1'b1, 1'b1, 1'b1, one ? 24'h000001 : {8'(y), 16'(i)});
        drv(1'b0, 1'b1, 1'b0, 24'h0);
        drv(1'b1, 1'b1, 1'b0, 24'h0);
    endtask

    task automatic vsync();
        drv(1'b1, 1'b0, 1'b0, 24'h0);
        drv(1'b1, 1'b0, 1'b0, 24'h0);
        drv(1'b1, 1'b1, 1'b0, 24'h0);
    endtask

    task automatic status(input string tag, input int cnt, input int last, input bit eh, input bit ev);
        chk({tag, "_cnt"},  32'(frame_cnt),  32'(cnt));
        chk({tag, "_last"}, 32'(last_lines), 32'(last));
        chk({tag, "_errh"}, 32'(err_hsize),  32'(eh));
        chk({tag, "_errv"}, 32'(err_vsize),  32'(ev));
    endtask

    initial begin
        rst = 1'b1; hs = 1'b1; vs = 1'b1; blank = 1'b0; rgb = 24'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid",  32'(pix_valid),  32'd0);
        chk("rst_x",      32'(pix_x),      32'd0);
        chk("rst_y",      32'(pix_y),      32'd0);
        chk("rst_rgb",    32'(pix_rgb),    32'd0);
        chk("rst_locked", 32'(locked),     32'd0);
        chk("rst_done",   32'(frame_done), 32'd0);
        status("rst", 0, 0, 1'b0, 1'b0);
`ifdef RX_CHECKSUM_EN
        chk("rst_sum", frame_sum, 32'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;

        // Partial frame before any vs edge is ignored
        pv0 = pv_cnt; fd0 = fd_cnt;
        for (int y = 0; y < 3; y++) line(20, y, 1'b0);
        chk("seek_locked", 32'(locked), 32'd0);
        chk("seek_valid",  32'(pv_cnt - pv0), 32'd0);
        chk("seek_done",   32'(fd_cnt - fd0), 32'd0);

        mon_en = 1'b1;
        vsync();
        chk("start_locked", 32'(locked), 32'd1);
        chk("start_done",   32'(fd_cnt - fd0), 32'd0);
        chk("start_cnt",    32'(frame_cnt), 32'd0);

        // Frame A: clean 160x90
        for (int y = 0; y < VD; y++) line(HD, y, 1'b0);
        vsync();
        mon_en = 1'b0;
        chk("a_done", 32'(fd_cnt - fd0), 32'd1);
        status("a", 1, 90, 1'b0, 1'b0);
        chk("a_npix",    32'(npix),    32'd14400);
        chk("a_pix_bad", 32'(pix_bad), 32'd0);
        chk("a_rows",    32'(my),      32'd90);

        // Frame C: line 10 short by one pixel
        for (int y = 0; y < VD; y++) line((y == 10) ? HD - 1 : HD, y, 1'b0);
        vsync();
        chk("c_done", 32'(fd_cnt - fd0), 32'd2);
        status("c", 2, 90, 1'b1, 1'b0);

        // Frame D: 88 clean lines
        for (int y = 0; y < 88; y++) line(HD, y, 1'b0);
        vsync();
        status("d", 3, 88, 1'b0, 1'b1);

        // Frame E: vs falls on the same sample blank falls after line 90, rgb constant 1
        for (int y = 0; y < VD - 1; y++) line(HD, y, 1'b1);
        for (int i = 0; i < HD; i++) drv(1'b1, 1'b1, 1'b1, 24'h000001);
        fd0 = fd_cnt;
        vsync();
        chk("e_done", 32'(fd_cnt - fd0), 32'd1);
        status("e", 4, 90, 1'b0, 1'b0);
`ifdef RX_CHECKSUM_EN
        chk("e_sum", frame_sum, 32'h0000_3840);
`endif

        // Frame without active pixels
        vsync();
        status("empty", 5, 0, 1'b0, 1'b1);

        // vs falls mid-run: partial third line counts as a faulty line
        line(HD, 0, 1'b0);
        line(HD, 1, 1'b0);
        for (int i = 0; i < 5; i++) drv(1'b1, 1'b1, 1'b1, 24'h0);
        drv(1'b1, 1'b0, 1'b1, 24'h0);
        drv(1'b1, 1'b0, 1'b0, 24'h0);
        drv(1'b1, 1'b1, 1'b0, 24'h0);
        status("partial", 6, 3, 1'b1, 1'b1);

        // The tail of that run must not leak into the next frame
        line(HD, 0, 1'b0);
        vsync();
        status("after_partial", 7, 1, 1'b0, 1'b1);

        // Reset at line 40 of a frame
        fd0 = fd_cnt;
        for (int y = 0; y < 40; y++) line(HD, y, 1'b0);
        for (int i = 0; i < 50; i++) drv(1'b1, 1'b1, 1'b1, 24'h0);
        rst = 1'b1;
        drv(1'b1, 1'b1, 1'b1, 24'h0);
        rst = 1'b0;
        chk("mrst_valid",  32'(pix_valid),  32'd0);
        chk("mrst_x",      32'(pix_x),      32'd0);
        chk("mrst_y",      32'(pix_y),      32'd0);
        chk("mrst_locked", 32'(locked),     32'd0);
        chk("mrst_done",   32'(frame_done), 32'd0);
        status("mrst", 0, 0, 1'b0, 1'b0);
        pv0 = pv_cnt;
        for (int i = 0; i < 110; i++) drv(1'b1, 1'b1, 1'b1, 24'h0);
        drv(1'b0, 1'b1, 1'b0, 24'h0);
        drv(1'b1, 1'b1, 1'b0, 24'h0);
        line(HD, 41, 1'b0);
        chk("mrst_locked2", 32'(locked), 32'd0);
        chk("mrst_valid2",  32'(pv_cnt - pv0), 32'd0);
        chk("mrst_nodone",  32'(fd_cnt - fd0), 32'd0);

        vsync();
        chk("relock_locked", 32'(locked), 32'd1);
        chk("relock_nodone", 32'(fd_cnt - fd0), 32'd0);
        chk("relock_cnt",    32'(frame_cnt), 32'd0);
        vsync();
        chk("relock_done", 32'(fd_cnt - fd0), 32'd1);
        status("relock", 1, 0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
